// File: rtl/sseg_array_drv.sv
// sseg_array_drv
//   Registered multi-digit hex driver for static seven-segment displays.
//   A packed nibble vector, decimal points and digit enables are captured
//   into shadow registers on a load strobe; every segment byte is then
//   decoded and registered, so the outputs have no combinational path from
//   any input. Adds leading-zero blanking, per-digit blink and lamp test.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-high
//   load       capture strobe for data / dp / digit_en
//   data       4 bits per digit, digit 0 = data[3:0]
//   dp         decimal point request per digit
//   digit_en   digit enable per digit (0 = blank)
//   blink_mask per-digit blink select, live input
//   lzb_en     leading-zero blanking enable, live input
//   lamp_test  force every segment and dp lit, live input
//   led        segment byte per digit {dp,g,f,e,d,c,b,a}, digit 0 = led[7:0]

module sseg_array_drv #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lzb_en,
  input  logic                    lamp_test,
  output logic [8*NUM_DIGITS-1:0] led
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
  localparam logic [8*NUM_DIGITS-1:0] LED_BLANK =
    (ACTIVE_LOW != 0) ? {(8*NUM_DIGITS){1'b1}} : '0;

  logic [4*NUM_DIGITS-1:0] data_q, data_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [8*NUM_DIGITS-1:0] led_q, led_d;

  // zero_from[i] = nibbles i..NUM_DIGITS-1 are all zero; the extra top
  // entry is the "nothing above" seed so the scan needs no special case.
  logic [NUM_DIGITS:0]     zero_from;

  // Active-high segment pattern for a hex nibble, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h27;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h58;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Shadow registers and the free-running blink divider. The divider is
  // deliberately independent of load so the blink cadence never jitters.
  always_comb begin
    data_d        = data_q;
    dp_d          = dp_q;
    en_d          = en_q;
    cnt_d         = cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (load) begin
      data_d = data;
      dp_d   = dp;
      en_d   = digit_en;
    end
    if (cnt_q == CNT_LAST) begin
      cnt_d         = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Per-digit output byte, built in active-high form and inverted at the
  // end for common-anode boards. Priority: lamp test, disable, leading
  // zero, blink, then the decoded nibble with its decimal point.
  always_comb begin
    logic [7:0] lit;
    zero_from             = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    led_d                 = '0;
    lit                   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] & (data_q[4*i +: 4] == 4'h0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lamp_test)
        lit = 8'hFF;
      else if (!en_q[i])
        lit = 8'h00;
      else if (lzb_en && (i != 0) && zero_from[i])
        lit = 8'h00;
      else if (blink_mask[i] && blink_phase_q)
        lit = 8'h00;
      else
        lit = {dp_q[i], hex_to_seg(data_q[4*i +: 4])};
      led_d[8*i +: 8] = (ACTIVE_LOW != 0) ? ~lit : lit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q        <= '0;
      dp_q          <= '0;
      en_q          <= '0;
      cnt_q         <= '0;
      blink_phase_q <= 1'b0;
      led_q         <= LED_BLANK;
    end else begin
      data_q        <= data_d;
      dp_q          <= dp_d;
      en_q          <= en_d;
      cnt_q         <= cnt_d;
      blink_phase_q <= blink_phase_d;
      led_q         <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_sseg_array_drv.sv
// Testbench for sseg_array_drv with NUM_DIGITS=6, BLINK_DIV=4, ACTIVE_LOW=1.
// Table-driven static vectors followed by hand-written sequences for
// reset, load latency and the blink cadence.

module tb_sseg_array_drv;

  logic        clk;
  logic        rst;
  logic        load;
  logic [23:0] data;
  logic [5:0]  dp;
  logic [5:0]  digit_en;
  logic [5:0]  blink_mask;
  logic        lzb_en;
  logic        lamp_test;
  logic [47:0] led;

  int n_checks;
  int n_fail;

  typedef struct {
    string       name;
    logic        load;
    logic [23:0] data;
    logic [5:0]  dp;
    logic [5:0]  en;
    logic        lzb;
    logic        lamp;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs[11];

  sseg_array_drv #(
    .NUM_DIGITS(6),
    .BLINK_DIV (4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data      (data),
    .dp        (dp),
    .digit_en  (digit_en),
    .blink_mask(blink_mask),
    .lzb_en    (lzb_en),
    .lamp_test (lamp_test),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [47:0] exp);
    n_checks++;
    if (led !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: led=%h expected=%h", name, led, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    load      = v.load;
    data      = v.data;
    dp        = v.dp;
    digit_en  = v.en;
    lzb_en    = v.lzb;
    lamp_test = v.lamp;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Release reset, load 00A05F with blink on digit 0 and follow the cadence.
  // Phase after edge m is (m/4)%2; led at edge n reflects state after n-1.
  task automatic blinkRun(input bit wrap_load, input string tag);
    logic [7:0] d0;
    int         m;
    @(negedge clk);
    rst        = 1'b0;
    load       = 1'b1;
    data       = 24'h00A05F;
    dp         = 6'h00;
    digit_en   = 6'h3F;
    blink_mask = 6'b000001;
    lzb_en     = 1'b0;
    lamp_test  = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) load = 1'b0;
      if (wrap_load && n == 7) begin
        load = 1'b1;
        data = 24'h00A05E;
      end
      if (n == 8) load = 1'b0;
      if (n >= 2) begin
        m = n - 1;
        if (((m / 4) % 2) == 1)       d0 = 8'hFF;
        else if (wrap_load && m >= 8) d0 = 8'h86;
        else                          d0 = 8'h8E;
        checkOutput($sformatf("%s_edge%0d", tag, n), {40'hC0C0_88C0_92, d0});
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    load       = 1'b0;
    data       = '0;
    dp         = '0;
    digit_en   = '0;
    blink_mask = '0;
    lzb_en     = 1'b0;
    lamp_test  = 1'b0;

    vecs[0]  = '{"basic",        1'b1, 24'h00A05F, 6'h00, 6'h3F, 1'b0, 1'b0, 48'hC0C0_88C0_928E};
    vecs[1]  = '{"hold_no_load", 1'b0, 24'h123456, 6'h00, 6'h3F, 1'b0, 1'b0, 48'hC0C0_88C0_928E};
    vecs[2]  = '{"lzb_live",     1'b0, 24'h123456, 6'h00, 6'h3F, 1'b1, 1'b0, 48'hFFFF_88C0_928E};
    vecs[3]  = '{"lzb_all_zero", 1'b1, 24'h000000, 6'h00, 6'h3F, 1'b1, 1'b0, 48'hFFFF_FFFF_FFC0};
    vecs[4]  = '{"dp_digit1",    1'b1, 24'h00A05F, 6'h02, 6'h3F, 1'b0, 1'b0, 48'hC0C0_88C0_128E};
    vecs[5]  = '{"digit0_off",   1'b1, 24'h00A05F, 6'h02, 6'h3E, 1'b0, 1'b0, 48'hC0C0_88C0_12FF};
    vecs[6]  = '{"lamp_test",    1'b1, 24'h00A05F, 6'h02, 6'h00, 1'b0, 1'b1, 48'h0000_0000_0000};
    vecs[7]  = '{"all_disabled", 1'b0, 24'h00A05F, 6'h02, 6'h00, 1'b0, 1'b0, 48'hFFFF_FFFF_FFFF};
    vecs[8]  = '{"digits_1to6",  1'b1, 24'h123456, 6'h00, 6'h3F, 1'b1, 1'b0, 48'hF9A4_B099_9282};
    vecs[9]  = '{"lzb_dp_supp",  1'b1, 24'h00B0C0, 6'h20, 6'h3F, 1'b1, 1'b0, 48'hFFFF_83C0_A7C0};
    vecs[10] = '{"lzb_ignore_en",1'b1, 24'h100000, 6'h00, 6'h1F, 1'b1, 1'b0, 48'hFFC0_C0C0_C0C0};

    // Reset state, with and without clock edges.
    #3;
    checkOutput("reset_async", 48'hFFFF_FFFF_FFFF);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_held", 48'hFFFF_FFFF_FFFF);
    rst = 1'b0;

    $display("[TB] static vectors");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // One-edge load: shadow updates at edge k, led at edge k+1.
    @(negedge clk);
    load     = 1'b1;
    data     = 24'h00A05F;
    dp       = 6'h00;
    digit_en = 6'h3F;
    lzb_en   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    data = 24'hFFFFFF;
    checkOutput("latency_before", 48'hFFC0_C0C0_C0C0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("latency_after", 48'hC0C0_88C0_928E);

    // Reset, then blink cadence with a load on a wrap edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset_before_blink", 48'hFFFF_FFFF_FFFF);
    $display("[TB] blink sequence with wrap load");
    blinkRun(1'b1, "blink_wrap");

    // Asynchronous reset mid-blink, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset_mid_blink", 48'hFFFF_FFFF_FFFF);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_mid_blink_held", 48'hFFFF_FFFF_FFFF);
    $display("[TB] blink sequence after reset");
    blinkRun(1'b0, "blink_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
